// File: rtl/add_tree_sched.sv
// add_tree_sched
//   Round-robin scheduler sharing one pipelined 8-input adder tree among
//   NUM_REQ requesters. At most one requester is granted per cycle. Its
//   operands are muxed onto the tree inputs. A tag pipeline whose depth
//   matches the tree latency returns each sum with the ID of its issuer.
//   An IDLE/RUN/DRAIN state machine lets software quiesce the tree.
//
// Parameters
//   WIDTH    operand / sum width (sums wrap modulo 2^WIDTH)
//   NUM_REQ  number of requesters (2..16)
//   LATENCY  adder tree pipeline depth, issue to tree_sum (>= 1)
//
// Ports
//   clk           clock
//   rst           synchronous active-low reset
//   en            scheduler enable; deasserting starts a drain
//   req           per-requester valid operand set
//   req_data      8 operands per requester
//   gnt           one-hot grant (or zero); issue = req & gnt
//   tree_inputs   operands of the granted requester, zero with no grant
//   tree_sum      adder tree output
//   result_valid  tree_sum holds a scheduled result this cycle
//   result_id     requester owning the current result (0 when not valid)
//   result        tree_sum passed through
//   busy          at least one issue still in flight
//   state_idle    FSM is in IDLE
//
// Optional feature, macro ADD_TREE_SCHED_STATS_EN:
//   stats_clr     input, synchronously clears all grant counters
//   grant_count   output, per-requester saturating 32-bit issue counters

module add_tree_sched #(
  parameter  int WIDTH   = 16,
  parameter  int NUM_REQ = 4,
  parameter  int LATENCY = 4,
  localparam int IDW     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  localparam int OUTW    = $clog2(LATENCY + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ-1:0][7:0][WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]                  gnt,
  output logic [7:0][WIDTH-1:0]               tree_inputs,
  input  logic [WIDTH-1:0]                    tree_sum,
  output logic                                result_valid,
  output logic [IDW-1:0]                      result_id,
  output logic [WIDTH-1:0]                    result,
  output logic                                busy,
  output logic                                state_idle
`ifdef ADD_TREE_SCHED_STATS_EN
  ,
  input  logic                                stats_clr,
  output logic [NUM_REQ-1:0][31:0]            grant_count
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]                    state;
  logic [IDW-1:0]                rr_ptr;
  logic [IDW-1:0]                winner;
  logic                          found;
  logic                          issue;
  int                            scan_idx;
  logic [OUTW-1:0]               outstanding;
  logic [LATENCY-1:0]            tag_valid;
  logic [LATENCY-1:0][IDW-1:0]   tag_id;

  // Round-robin search: first requester at or above rr_ptr, wrapping.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!found && req[scan_idx]) begin
        found  = 1'b1;
        winner = IDW'(scan_idx);
      end
    end
  end

  // Grants exist only while running; a grant is always an issue.
  assign issue = (state == ST_RUN) && found;

  always_comb begin
    gnt         = '0;
    tree_inputs = '0;
    if (issue) begin
      gnt[winner] = 1'b1;
      tree_inputs = req_data[winner];
    end
  end

  // Enable/drain state machine. DRAIN waits on the registered
  // outstanding count, so it exits one edge after the last retire.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (en) state <= ST_RUN;
        ST_RUN:   if (!en) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (outstanding == '0) state <= ST_IDLE;
          else if (en)           state <= ST_RUN;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Pointer moves past the winner after each issue, otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);
    end
  end

  // Tag pipeline aligned with the tree; reset drops all in-flight tags so
  // orphaned sums are never flagged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid[0] <= issue;
      tag_id[0]    <= winner;
      for (int k = 1; k < LATENCY; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_id[k]    <= tag_id[k-1];
      end
    end
  end

  assign result_valid = tag_valid[LATENCY-1];
  assign result_id    = result_valid ? tag_id[LATENCY-1] : '0;
  assign result       = tree_sum;

  // At most LATENCY issues can be in flight, so this cannot overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + OUTW'(issue) - OUTW'(result_valid);
    end
  end

  assign busy       = (outstanding != '0);
  assign state_idle = (state == ST_IDLE);

`ifdef ADD_TREE_SCHED_STATS_EN
  // Saturating issue counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst || stats_clr) begin
      grant_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (issue && (winner == IDW'(i)) && (grant_count[i] != 32'hFFFF_FFFF)) begin
          grant_count[i] <= grant_count[i] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_add_tree_sched.sv
// tb_add_tree_sched
//   Self-checking bench for add_tree_sched (default parameters). A small
//   pipelined adder model stands in for the shared tree. Per-cycle
//   expectations live in a table of hand-computed records; the overflow
//   and statistics corner cases are hand-written sequences.
//   Requester i operand j = (j+1) + 10*(i^1), so the sums are
//   req0=116, req1=36, req2=276, req3=196.

module tb_add_tree_sched;

  localparam int WIDTH   = 16;
  localparam int NUM_REQ = 4;
  localparam int LATENCY = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       en;
  logic [3:0]                 req;
  logic [3:0][7:0][15:0]      req_data;
  logic [3:0]                 gnt;
  logic [7:0][15:0]           tree_inputs;
  logic [15:0]                tree_sum;
  logic                       result_valid;
  logic [1:0]                 result_id;
  logic [15:0]                result;
  logic                       busy;
  logic                       state_idle;
`ifdef ADD_TREE_SCHED_STATS_EN
  logic                       stats_clr;
  logic [3:0][31:0]           grant_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  add_tree_sched #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ),
    .LATENCY (LATENCY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .tree_inputs  (tree_inputs),
    .tree_sum     (tree_sum),
    .result_valid (result_valid),
    .result_id    (result_id),
    .result       (result),
    .busy         (busy),
    .state_idle   (state_idle)
`ifdef ADD_TREE_SCHED_STATS_EN
    ,
    .stats_clr    (stats_clr),
    .grant_count  (grant_count)
`endif
  );

  // Stand-in adder tree: 8-input wrap-around sum, LATENCY stages deep.
  logic [15:0] tree_add;
  logic [15:0] tree_pipe [LATENCY];

  always_comb begin
    tree_add = '0;
    for (int j = 0; j < 8; j++) tree_add = tree_add + tree_inputs[j];
  end

  always_ff @(posedge clk) begin
    tree_pipe[0] <= tree_add;
    for (int k = 1; k < LATENCY; k++) tree_pipe[k] <= tree_pipe[k-1];
  end

  assign tree_sum = tree_pipe[LATENCY-1];

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic        chk;
    logic [3:0]  gnt;
    logic        valid;
    logic [1:0]  id;
    logic [15:0] res;
    logic        busy;
    logic        idle;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic e, input logic [3:0] rq,
                              input logic c, input logic [3:0] g, input logic v,
                              input logic [1:0] id, input logic [15:0] res,
                              input logic b, input logic idl);
    vec_t t;
    t.rst = r; t.en = e; t.req = rq; t.chk = c; t.gnt = g;
    t.valid = v; t.id = id; t.res = res; t.busy = b; t.idle = idl;
    return t;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Operands the tree should see for an expected grant vector.
  function automatic logic [127:0] exp_operands(input logic [3:0] g);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) if (g[i]) v = req_data[i];
    return v;
  endfunction

  task automatic apply_stimulus(input vec_t t);
    @(posedge clk);
    #1;
    rst = t.rst;
    en  = t.en;
    req = t.req;
  endtask

  task automatic check_output(input vec_t t, input int row);
    string tag;
    tag = $sformatf("row%0d", row);
    check({tag, "_gnt"},   128'(gnt),          128'(t.gnt));
    check({tag, "_tin"},   tree_inputs,        exp_operands(t.gnt));
    check({tag, "_valid"}, 128'(result_valid), 128'(t.valid));
    check({tag, "_id"},    128'(result_id),    128'(t.id));
    check({tag, "_busy"},  128'(busy),         128'(t.busy));
    check({tag, "_idle"},  128'(state_idle),   128'(t.idle));
    if (t.valid) check({tag, "_result"}, 128'(result), 128'(t.res));
  endtask

  initial begin
    int n_res;

    rst = 1'b0;
    en  = 1'b0;
    req = '0;
`ifdef ADD_TREE_SCHED_STATS_EN
    stats_clr = 1'b0;
`endif
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++)
        req_data[i][j] = 16'(j + 1 + 10 * (i ^ 1));

    // Test 1: single issue from requester 1
    vecs.push_back(mk(1,1,4'b0000, 1, 4'b0000,0,0,0,   0,1));
    vecs.push_back(mk(1,1,4'b0010, 1, 4'b0010,0,0,0,   0,0));
    vecs.push_back(mk(1,1,4'b0000, 1, 4'b0000,0,0,0,   1,0));
    vecs.push_back(mk(1,1,4'b0000, 1, 4'b0000,0,0,0,   1,0));
    vecs.push_back(mk(1,1,4'b0000, 1, 4'b0000,0,0,0,   1,0));
    vecs.push_back(mk(1,1,4'b0000, 1, 4'b0000,1,1,36,  1,0));
    vecs.push_back(mk(1,1,4'b0000, 1, 4'b0000,0,0,0,   0,0));
    vecs.push_back(mk(0,0,4'b0000, 0, 4'b0000,0,0,0,   0,0));
    // Test 2: round-robin over all four requesters
    vecs.push_back(mk(1,1,4'b0000, 1, 4'b0000,0,0,0,   0,1));
    vecs.push_back(mk(1,1,4'b1111, 1, 4'b0001,0,0,0,   0,0));
    vecs.push_back(mk(1,1,4'b1111, 1, 4'b0010,0,0,0,   1,0));
    vecs.push_back(mk(1,1,4'b1111, 1, 4'b0100,0,0,0,   1,0));
    vecs.push_back(mk(1,1,4'b1111, 1, 4'b1000,0,0,0,   1,0));
    vecs.push_back(mk(1,1,4'b1111, 1, 4'b0001,1,0,116, 1,0));
    vecs.push_back(mk(1,1,4'b1111, 1, 4'b0010,1,1,36,  1,0));
    vecs.push_back(mk(1,1,4'b1111, 1, 4'b0100,1,2,276, 1,0));
    vecs.push_back(mk(1,1,4'b1111, 1, 4'b1000,1,3,196, 1,0));
    vecs.push_back(mk(1,1,4'b0000, 1, 4'b0000,1,0,116, 1,0));
    vecs.push_back(mk(1,1,4'b0000, 1, 4'b0000,1,1,36,  1,0));
    vecs.push_back(mk(1,1,4'b0000, 1, 4'b0000,1,2,276, 1,0));
    vecs.push_back(mk(1,1,4'b0000, 1, 4'b0000,1,3,196, 1,0));
    vecs.push_back(mk(1,1,4'b0000, 1, 4'b0000,0,0,0,   0,0));
    // Test 3: grant 2, then pointer at 3 skips 1 and 2
    vecs.push_back(mk(1,1,4'b0100, 1, 4'b0100,0,0,0,   0,0));
    vecs.push_back(mk(1,1,4'b1001, 1, 4'b1000,0,0,0,   1,0));
    vecs.push_back(mk(1,1,4'b1001, 1, 4'b0001,0,0,0,   1,0));
    vecs.push_back(mk(1,1,4'b0000, 1, 4'b0000,0,0,0,   1,0));
    vecs.push_back(mk(1,1,4'b0000, 1, 4'b0000,1,2,276, 1,0));
    vecs.push_back(mk(1,1,4'b0000, 1, 4'b0000,1,3,196, 1,0));
    vecs.push_back(mk(1,1,4'b0000, 1, 4'b0000,1,0,116, 1,0));
    vecs.push_back(mk(1,1,4'b0000, 1, 4'b0000,0,0,0,   0,0));
    // Test 4: three issues, then drain with requests still pending
    vecs.push_back(mk(1,1,4'b1111, 1, 4'b0010,0,0,0,   0,0));
    vecs.push_back(mk(1,1,4'b1111, 1, 4'b0100,0,0,0,   1,0));
    vecs.push_back(mk(1,1,4'b1111, 1, 4'b1000,0,0,0,   1,0));
    vecs.push_back(mk(1,0,4'b0000, 1, 4'b0000,0,0,0,   1,0));
    vecs.push_back(mk(1,0,4'b1111, 1, 4'b0000,1,1,36,  1,0));
    vecs.push_back(mk(1,0,4'b1111, 1, 4'b0000,1,2,276, 1,0));
    vecs.push_back(mk(1,0,4'b1111, 1, 4'b0000,1,3,196, 1,0));
    vecs.push_back(mk(1,0,4'b1111, 1, 4'b0000,0,0,0,   0,0));
    vecs.push_back(mk(1,0,4'b1111, 1, 4'b0000,0,0,0,   0,1));
    vecs.push_back(mk(1,0,4'b0000, 1, 4'b0000,0,0,0,   0,1));
    // Test 5: reset two cycles after an issue; orphaned sum ignored
    vecs.push_back(mk(1,1,4'b0000, 1, 4'b0000,0,0,0,   0,1));
    vecs.push_back(mk(1,1,4'b0001, 1, 4'b0001,0,0,0,   0,0));
    vecs.push_back(mk(1,1,4'b0000, 1, 4'b0000,0,0,0,   1,0));
    vecs.push_back(mk(0,1,4'b0000, 0, 4'b0000,0,0,0,   0,0));
    vecs.push_back(mk(1,0,4'b0000, 1, 4'b0000,0,0,0,   0,1));
    vecs.push_back(mk(1,0,4'b0000, 1, 4'b0000,0,0,0,   0,1));
    vecs.push_back(mk(1,0,4'b0000, 1, 4'b0000,0,0,0,   0,1));

    // Power-on reset and reset-state check
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_gnt",   128'(gnt),          128'(0));
    check("rst_tin",   tree_inputs,        128'(0));
    check("rst_valid", 128'(result_valid), 128'(0));
    check("rst_id",    128'(result_id),    128'(0));
    check("rst_busy",  128'(busy),         128'(0));
    check("rst_idle",  128'(state_idle),   128'(1));

    foreach (vecs[r]) begin
      apply_stimulus(vecs[r]);
      #1;
      if (vecs[r].chk) check_output(vecs[r], r);
    end

    // Overflow: 8 x 0xFFFF wraps to 0xFFF8, five issues from requester 0
    for (int j = 0; j < 8; j++) req_data[0][j] = 16'hFFFF;
    @(posedge clk);
    #1;
    en  = 1'b1;
    req = 4'b0000;
    n_res = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      req = (c < 5) ? 4'b0001 : 4'b0000;
      #1;
      check($sformatf("ovf_gnt%0d", c), 128'(gnt), (c < 5) ? 128'(1) : 128'(0));
      if (result_valid) begin
        n_res++;
        check($sformatf("ovf_result%0d", c), 128'(result),    128'(16'hFFF8));
        check($sformatf("ovf_id%0d", c),     128'(result_id), 128'(0));
      end
    end
    check("ovf_result_count", 128'(n_res), 128'(5));
    check("ovf_busy_end",     128'(busy),  128'(0));

`ifdef ADD_TREE_SCHED_STATS_EN
    check("stats_cnt0", 128'(grant_count[0]), 128'(5));
    check("stats_cnt1", 128'(grant_count[1]), 128'(0));
    @(posedge clk);
    #1;
    stats_clr = 1'b1;
    req       = 4'b0001;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    req       = 4'b0000;
    #1;
    check("stats_clr0", 128'(grant_count[0]), 128'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/add_tree_sched.md
Name: add_tree_sched

Overview:
- Round-robin scheduler that shares one pipelined 8-input adder tree among NUM_REQ requesters.
- Each cycle it grants at most one requester and muxes that requester's 8 operands onto the tree inputs.
- A tag pipeline matched to the tree latency routes each sum back with the ID of the requester that issued it.
- An enable/drain state machine lets software quiesce the shared tree cleanly.

Parameters:
- WIDTH, 16: operand and sum width in bits; the tree wraps sums modulo 2^WIDTH.
- NUM_REQ, 4: number of requesters; legal range 2..16.
- LATENCY, 4: cycles from issue to tree_sum valid; must equal the attached tree's pipeline depth; minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- en  in  1  scheduler enable; deasserting it starts a drain
- req  in  NUM_REQ  req[i]=1: requester i holds a valid operand set
- req_data  in  [NUM_REQ][8] x WIDTH  operand sets, one per requester
- gnt  out  NUM_REQ  one-hot or zero; issue to i occurs when req[i] & gnt[i]
- tree_inputs  out  [8] x WIDTH  operands of the granted requester; all zero when there is no grant
- tree_sum  in  WIDTH  adder tree output
- result_valid  out  1  tree_sum carries a scheduled result this cycle
- result_id  out  max(1,$clog2(NUM_REQ))  requester that owns the current result
- result  out  WIDTH  equals tree_sum
- busy  out  1  one or more issues are still in flight
- state_idle  out  1  FSM is in IDLE

Behaviour:
- Reset (rst=0 at an edge) clears all state:
  - FSM goes to IDLE; rr_ptr=0; tag pipeline valid bits=0; outstanding=0.
  - Outputs after reset: gnt=0, tree_inputs=0, result_valid=0, result_id=0, busy=0, state_idle=1.
- Reset mid-operation discards all in-flight tags. Tree sums that arrive afterwards are never flagged valid.
- FSM states and transitions:
  - IDLE: when en=1, go to RUN.
  - RUN: when en=0, go to DRAIN.
  - DRAIN: when outstanding=0, go to IDLE. If en=1 while still draining, go back to RUN.
  - DRAIN with outstanding already 0 reaches IDLE on the next edge.
- Grants are issued only in RUN.
  - gnt is combinational from req and rr_ptr.
  - The winner is the first i with req[i]=1, searching from rr_ptr upward with wrap-around.
- rr_ptr update:
  - After an issue to requester i, rr_ptr becomes (i+1) mod NUM_REQ; i=NUM_REQ-1 wraps to 0.
  - With no issue, rr_ptr holds.
- tree_inputs is a combinational mux of req_data[winner]; the tree samples it on the issue edge.
- Tag pipeline:
  - A shift register LATENCY deep; each stage holds {valid, id}.
  - Stage 0 loads {issue, winner} every cycle.
- Latency: an issue in cycle t gives result_valid=1 and result_id=winner in cycle t+LATENCY, with result=tree_sum. Throughput is 1 issue per cycle.
- result_valid=0 in every cycle that has no matching issue. tree_sum is ignored in those cycles.
- outstanding counter:
  - Counts +1 per issue and -1 per result_valid; simultaneous issue and retire leaves it unchanged.
  - Range is 0..LATENCY and it never overflows.
  - busy = (outstanding != 0).
- Results have no backpressure; requesters must accept result_valid whenever it is asserted.
- A requester may hold req=1 across cycles; each granted cycle is one separate issue.

Optional Feature:
- Macro: ADD_TREE_SCHED_STATS_EN
- Defined:
  - Adds output grant_count, a [NUM_REQ] array of 32-bit counters.
  - Entry i increments on every issue to requester i and saturates at 0xFFFFFFFF.
  - All entries clear on reset.
  - Adds input stats_clr; when high it clears all counters synchronously and takes priority over increments.
- Not defined: those ports and counters do not exist, and all other behaviour is unchanged.

Test Plan:
1. Single issue: reset, en=1, req=4'b0010 for one cycle with req_data[1]={1,2,3,4,5,6,7,8}.
   Expect gnt=4'b0010 that cycle; 4 cycles later result_valid=1, result_id=1, result=36; busy=1 for exactly those 4 cycles.
2. Round-robin fairness: req=4'b1111 held for 8 cycles.
   Expect grant order 0,1,2,3,0,1,2,3; results return in the same order, one per cycle, starting 4 cycles after the first issue.
3. Pointer wrap and skip: rr_ptr=3 after granting 2, then req=4'b1001.
   Expect grant to 3, then to 0; requesters 1 and 2 are never granted.
4. Drain: en dropped in the cycle after 3 back-to-back issues.
   Expect no further gnt; state leaves DRAIN only once all 3 results have come out, and state_idle=1 on the following cycle.
5. Reset mid-flight: rst=0 for one cycle 2 cycles after an issue.
   Expect all outputs at their reset values; no result_valid for the orphaned sum; outstanding=0.
6. Overflow plus stats (macro defined): operands of 0xFFFF on all 8 inputs, 5 issues from requester 0.
   Expect result=0xFFF8 each time and grant_count[0]=5; after stats_clr, grant_count[0]=0.
